data_sram_resp: RTL and testbench

Responder end of the pipeline data-SRAM interface: it receives the execute stage's `data_sram_en/we/addr/wdata` requests and returns `data_sram_rdata` one cycle later for the memory stage. Storage is an internal word array with byte write enables. After reset, an init sequencer zeroes the whole array. Out-of-window accesses are flagged. The block replaces the external SRAM model on the simulation/FPGA build.

---
 rtl/data_sram_resp.sv | 105 ++++++++++
 tb/tb_data_sram_resp.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: word array with byte enables, post-reset clear sequencer,
// out-of-window flagging. Define DATA_SRAM_WRITE_FIRST_EN for write-first store read data.
module data_sram_resp #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h1c08_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        hold,
  output logic [31:0] data_sram_rdata,
  output logic        init_busy,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {INIT, READY} state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] clr_idx;
  logic [31:0]           mem [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_win;
  logic                  accept;
  logic [31:0]           cur_word;
  logic [31:0]           merged;
  logic [3:0]            mem_we;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [31:0]           wr_data;
  logic                  unused_addr_lsb;

  assign idx             = data_sram_addr[DEPTH_LOG2+1:2];
  assign in_win          = data_sram_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2];
  assign accept          = (state == READY) && data_sram_en && !hold;
  assign init_busy       = (state == INIT);
  assign cur_word        = mem[idx];
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  always_comb begin
    merged = cur_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (data_sram_we[b]) merged[8*b +: 8] = data_sram_wdata[8*b +: 8];
    end
  end

  // The clear sequencer and the request path share the single array write port.
  always_comb begin
    mem_we  = '0;
    wr_idx  = idx;
    wr_data = data_sram_wdata;
    if (state == INIT) begin
      mem_we  = '1;
      wr_idx  = clr_idx;
      wr_data = '0;
    end else if (accept && in_win) begin
      mem_we  = data_sram_we;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (mem_we[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= INIT;
      clr_idx         <= '0;
      data_sram_rdata <= '0;
      addr_err        <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        INIT: begin
          clr_idx <= clr_idx + DEPTH_LOG2'(1);
          if (clr_idx == '1) state <= READY;
        end
        READY: begin
          if (accept) begin
            if (!in_win) begin
              data_sram_rdata <= '0;
              addr_err        <= 1'b1;
            end else if (data_sram_we == 4'h0) begin
              data_sram_rdata <= cur_word;
            end else begin
`ifdef DATA_SRAM_WRITE_FIRST_EN
              data_sram_rdata <= merged;
`else
              data_sram_rdata <= cur_word;
`endif
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed self-checking bench for data_sram_resp (default geometry, 1024 words).
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        hold;
  logic [31:0] data_sram_rdata;
  logic        init_busy;
  logic        addr_err;

  int n_checks = 0;
  int n_fails  = 0;

  data_sram_resp #(.DEPTH_LOG2(10), .BASE_ADDR(32'h1c08_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .hold            (hold),
    .data_sram_rdata (data_sram_rdata),
    .init_busy       (init_busy),
    .addr_err        (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic hd);
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    hold            = hd;
  endtask

  task automatic step(input logic en, input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic hd);
    drive(en, we, addr, wdata, hd);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_st1, exp_st2;
  int          n_busy;

  initial begin
`ifdef DATA_SRAM_WRITE_FIRST_EN
    exp_st1 = 32'hDEADBEEF;
    exp_st2 = 32'hDEAABEEF;
`else
    exp_st1 = 32'h0000_0000;
    exp_st2 = 32'hDEADBEEF;
`endif
    reset = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_addr_err", {31'b0, addr_err}, 32'h0);
    check("reset_init_busy", {31'b0, init_busy}, 32'h1);
    reset = 1'b1;

    // Edge k below is the k-th rising edge after reset release, counting from 0.
    for (int k = 0; k < 1024; k++) begin
      if (k == 500)      drive(1'b1, 4'h0, 32'h1c08_0010, 32'h0, 1'b0);
      else if (k == 501) drive(1'b1, 4'h0, 32'h1c09_0000, 32'h0, 1'b0);
      else if (k == 502) drive(1'b1, 4'hF, 32'h1c08_0010, 32'h5555_5555, 1'b0);
      else               drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      if (k == 500) check("init_load_ignored", data_sram_rdata, 32'h0);
      if (k == 501) check("init_no_addr_err", {31'b0, addr_err}, 32'h0);
      if (k == 1022) check("init_busy_edge1022", {31'b0, init_busy}, 32'h1);
      if (k == 1023) check("init_busy_edge1023", {31'b0, init_busy}, 32'h0);
    end

    step(1'b1, 4'hF, 32'h1c08_0010, 32'hDEADBEEF, 1'b0);
    check("store_full_rdata", data_sram_rdata, exp_st1);
    step(1'b1, 4'h0, 32'h1c08_0010, 32'h0, 1'b0);
    check("load_after_store", data_sram_rdata, 32'hDEADBEEF);

    step(1'b1, 4'b0100, 32'h1c08_0010, 32'h00AA_0000, 1'b0);
    check("store_byte_rdata", data_sram_rdata, exp_st2);
    step(1'b1, 4'h0, 32'h1c08_0010, 32'h0, 1'b0);
    check("load_merged", data_sram_rdata, 32'hDEAABEEF);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'h0, 32'h1c08_0020, 32'h0, 1'b1);
      check("hold_load_rdata", data_sram_rdata, 32'hDEAABEEF);
    end
    step(1'b1, 4'hF, 32'h1c08_0010, 32'h1111_1111, 1'b1);
    check("hold_store_rdata", data_sram_rdata, 32'hDEAABEEF);
    step(1'b1, 4'h0, 32'h1c08_0020, 32'h0, 1'b0);
    check("load_zero_word", data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'h1c08_0013, 32'h0, 1'b0);
    check("hold_store_dropped", data_sram_rdata, 32'hDEAABEEF);

    step(1'b1, 4'h0, 32'h1c09_0000, 32'h0, 1'b0);
    check("oow_addr_err", {31'b0, addr_err}, 32'h1);
    check("oow_rdata", data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'h1c08_0010, 32'h0, 1'b0);
    check("oow_pulse_end", {31'b0, addr_err}, 32'h0);
    check("inwin_after_oow", data_sram_rdata, 32'hDEAABEEF);

    step(1'b1, 4'hF, 32'h1c09_0014, 32'hBAD0_BAD0, 1'b0);
    check("oow_store_err", {31'b0, addr_err}, 32'h1);
    step(1'b1, 4'b0011, 32'h1c08_0014, 32'h0000_CAFE, 1'b0);
    step(1'b1, 4'h0, 32'h1c08_0014, 32'h0, 1'b0);
    check("halfword_store_load", data_sram_rdata, 32'h0000_CAFE);

    step(1'b1, 4'hF, 32'h1c08_0030, 32'h1234_5678, 1'b0);
    step(1'b1, 4'h0, 32'h1c08_0030, 32'h0, 1'b0);
    check("load_before_reset", data_sram_rdata, 32'h1234_5678);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    #1;
    check("midreset_rdata", data_sram_rdata, 32'h0);
    check("midreset_init_busy", {31'b0, init_busy}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    n_busy = 0;
    while (n_busy < 2000) begin
      @(posedge clk);
      #1;
      n_busy++;
      if (!init_busy) break;
    end
    check("reinit_edges", n_busy, 32'd1024);
    step(1'b1, 4'h0, 32'h1c08_0030, 32'h0, 1'b0);
    check("reinit_cleared", data_sram_rdata, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
